pipe_sub: RTL and testbench



---
 rtl/pipe_arith_pkg.sv | 12 +
 rtl/sub_slice.sv | 14 +
 rtl/pipe_sub.sv | 90 +++++++++
 tb/tb_pipe_sub.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pipe_arith_pkg.sv
// Shared widths and result type for the pipelined add/sub check path.
package pipe_arith_pkg;

  localparam int unsigned W_DEF = 8;
  localparam int unsigned HALF  = W_DEF / 2;

  typedef struct packed {
    logic [W_DEF-1:0] diff;
    logic             err;
  } sub_res_t;

endpackage

// File: rtl/sub_slice.sv
// Combinational N-bit subtract-with-borrow slice: {bout, d} = a - b - bin.
module sub_slice #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_bin,
  output logic [N-1:0] o_d,
  output logic         o_bout
);

  assign {o_bout, o_d} = {1'b0, i_a} - {1'b0, i_b} - (N+1)'(i_bin);

endmodule

// File: rtl/pipe_sub.sv
// Two-stage pipelined subtractor recovering a = sum - b, with overflow/underflow flag
// and a valid/ready handshake that stalls both stages together.
module pipe_sub
  import pipe_arith_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W:0]   sum,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         err
);

  localparam int unsigned HW = W / 2;

  logic          r_v1;
  logic [HW-1:0] r_lo;
  logic          r_lo_borrow;
  logic [HW:0]   r_sum_hi;
  logic [HW-1:0] r_b_hi;

  logic          r_v2;
  logic [W-1:0]  r_diff;
  logic          r_err;

  logic          w_stall;
  logic          w_in_xfer;
  logic [HW-1:0] w_lo;
  logic          w_lo_borrow;
  logic [HW:0]   w_hi;
  logic          w_hi_borrow;

  assign w_stall   = r_v2 & ~out_ready;
  assign in_ready  = ~w_stall;
  assign w_in_xfer = in_valid & in_ready;

  sub_slice #(.N(HW)) u_lo (
    .i_a    (sum[HW-1:0]),
    .i_b    (b[HW-1:0]),
    .i_bin  (1'b0),
    .o_d    (w_lo),
    .o_bout (w_lo_borrow)
  );

  // High half keeps the sum's carry bit; a set result MSB means difference >= 2^W.
  sub_slice #(.N(HW+1)) u_hi (
    .i_a    (r_sum_hi),
    .i_b    ({1'b0, r_b_hi}),
    .i_bin  (r_lo_borrow),
    .o_d    (w_hi),
    .o_bout (w_hi_borrow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1        <= 1'b0;
      r_lo        <= '0;
      r_lo_borrow <= 1'b0;
      r_sum_hi    <= '0;
      r_b_hi      <= '0;
      r_v2        <= 1'b0;
      r_diff      <= '0;
      r_err       <= 1'b0;
    end else if (!w_stall) begin
      r_v1 <= w_in_xfer;
      r_v2 <= r_v1;
      if (w_in_xfer) begin
        r_lo        <= w_lo;
        r_lo_borrow <= w_lo_borrow;
        r_sum_hi    <= sum[W:HW];
        r_b_hi      <= b[W-1:HW];
      end
      if (r_v1) begin
        r_diff <= {w_hi[HW-1:0], r_lo};
        r_err  <= w_hi_borrow | w_hi[HW];
      end
    end
  end

  assign out_valid = r_v2;
  assign diff      = r_diff;
  assign err       = r_err;

endmodule

// File: tb/tb_pipe_sub.sv
// Directed self-checking bench for pipe_sub: latency, arithmetic corners, stall, reset.
module tb_pipe_sub;
  import pipe_arith_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [8:0]   sum;
  logic [7:0]   b;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   diff;
  logic         err;

  int checks   = 0;
  int failures = 0;
  sub_res_t exp_q[$];
  int delivered = 0;

  always #5 clk = ~clk;

  pipe_sub #(.W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs, record accepted item with its hand-computed result,
  // score any output transfer, then advance to 1 ns past the next rising edge.
  task automatic cyc(input logic iv, input logic [8:0] s, input logic [7:0] bv,
                     input logic ordy, input logic [7:0] ediff, input logic eerr);
    sub_res_t r;
    in_valid  = iv;
    sum       = s;
    b         = bv;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        delivered++;
        chk("diff", 32'(diff), 32'(r.diff));
        chk("err", 32'(err), 32'(r.err));
      end
    end
    if (in_valid && in_ready) exp_q.push_back('{diff: ediff, err: eerr});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 9'd0, 8'd0, 1'b1, 8'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; sum = '0; b = '0; out_ready = 1'b1;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    #7 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Basic stream with latency checks on the first item
    cyc(1'b1, 9'd30, 8'd20, 1'b1, 8'd10, 1'b0);
    chk("lat_edge1_out_valid", 32'(out_valid), 32'd0);
    cyc(1'b1, 9'd40, 8'd15, 1'b1, 8'd25, 1'b0);
    chk("lat_edge2_out_valid", 32'(out_valid), 32'd1);
    cyc(1'b1, 9'd70, 8'd30, 1'b1, 8'd40, 1'b0);
    cyc(1'b1, 9'd110, 8'd50, 1'b1, 8'd60, 1'b0);
    chk("throughput_valid", 32'(out_valid), 32'd1);
    idle(2);
    chk("basic_drained", 32'(exp_q.size()), 32'd0);
    chk("basic_delivered", 32'(delivered), 32'd4);
    idle(1);
    chk("basic_idle_valid", 32'(out_valid), 32'd0);

    // Error and borrow-across-halves cases, plus boundaries
    cyc(1'b1, 9'd5,   8'd6,   1'b1, 8'd255, 1'b1);
    cyc(1'b1, 9'd300, 8'd10,  1'b1, 8'd34,  1'b1);
    cyc(1'b1, 9'd265, 8'd10,  1'b1, 8'd255, 1'b0);
    cyc(1'b1, 9'd16,  8'd1,   1'b1, 8'd15,  1'b0);
    cyc(1'b1, 9'd256, 8'd1,   1'b1, 8'd255, 1'b0);
    cyc(1'b1, 9'd200, 8'd200, 1'b1, 8'd0,   1'b0);
    cyc(1'b1, 9'd511, 8'd0,   1'b1, 8'd255, 1'b1);
    cyc(1'b1, 9'd255, 8'd255, 1'b1, 8'd0,   1'b0);
    idle(3);
    chk("err_drained", 32'(exp_q.size()), 32'd0);
    chk("err_delivered", 32'(delivered), 32'd12);

    // Backpressure: stall three cycles right after the first output transfer
    cyc(1'b1, 9'd10, 8'd1, 1'b1, 8'd9,  1'b0);
    cyc(1'b1, 9'd20, 8'd2, 1'b1, 8'd18, 1'b0);
    cyc(1'b1, 9'd30, 8'd3, 1'b1, 8'd27, 1'b0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; sum = 9'd40; b = 8'd4; out_ready = 1'b0;
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_diff", 32'(diff), 32'd18);
      chk("stall_err", 32'(err), 32'd0);
      @(posedge clk); #1;
    end
    cyc(1'b1, 9'd40, 8'd4, 1'b1, 8'd36, 1'b0);
    idle(3);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_delivered", 32'(delivered), 32'd16);
    chk("bp_idle_valid", 32'(out_valid), 32'd0);

    // Reset mid-flight with two items in the pipe
    cyc(1'b1, 9'd50, 8'd5, 1'b1, 8'd45, 1'b0);
    cyc(1'b1, 9'd60, 8'd6, 1'b1, 8'd54, 1'b0);
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_no_stale0", 32'(out_valid), 32'd0);
    idle(2);
    chk("post_rst_no_stale1", 32'(out_valid), 32'd0);
    cyc(1'b1, 9'd2, 8'd1, 1'b1, 8'd1, 1'b0);
    chk("new_lat1", 32'(out_valid), 32'd0);
    idle(1);
    chk("new_lat2", 32'(out_valid), 32'd1);
    chk("new_diff", 32'(diff), 32'd1);
    chk("new_err", 32'(err), 32'd0);
    idle(2);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
